// File: rtl/fft_uart_sequencer.sv
// Frame sequencer between UART RX, the FFT core and UART TX: collects FFT_SIZE
// sample bytes, runs the FFT, then streams 2*FFT_SIZE result bytes to the transmitter.
module fft_uart_sequencer #(
    parameter int FFT_SIZE = 32,
    parameter int SEL_W    = 6,
    parameter int TIMEOUT  = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_valid,
    input  logic             i_fft_done,
    input  logic             i_tx_done,
    output logic             o_rx_enable,
    output logic             o_fft_run,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_tx_start,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_error
);
    localparam int CNT_W    = $clog2(FFT_SIZE) + 1;
    localparam int WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_SEL = 2 * FFT_SIZE - 1;

    typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, SEND} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WD_W-1:0]  wd, wd_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             start_pend, start_pend_nxt;
    logic             rx_en_nxt, run_nxt, start_nxt, busy_nxt, fdone_nxt, err_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            start_pend   <= 1'b0;
            o_rx_enable  <= 1'b1;
            o_fft_run    <= 1'b0;
            o_sel        <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            wd           <= wd_nxt;
            start_pend   <= start_pend_nxt;
            o_rx_enable  <= rx_en_nxt;
            o_fft_run    <= run_nxt;
            o_sel        <= sel_nxt;
            o_tx_start   <= start_nxt;
            o_busy       <= busy_nxt;
            o_frame_done <= fdone_nxt;
            o_error      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wd_nxt         = wd;
        sel_nxt        = o_sel;
        start_pend_nxt = 1'b0;
        rx_en_nxt      = o_rx_enable;
        run_nxt        = o_fft_run;
        start_nxt      = 1'b0;
        fdone_nxt      = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            IDLE: begin
                rx_en_nxt = 1'b1;
                run_nxt   = 1'b0;
                wd_nxt    = '0;
                if (i_rx_valid) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = CNT_W'(1);
                    run_nxt   = 1'b1;
                end
            end
            COLLECT: begin
                // A byte arriving on the expiry edge wins over the watchdog.
                if (i_rx_valid) begin
                    wd_nxt  = '0;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FFT_SIZE - 1)) begin
                        state_nxt = COMPUTE;
                        rx_en_nxt = 1'b0;
                    end
                end else if (TIMEOUT != 0 && wd == WD_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    run_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    wd_nxt    = '0;
                end else if (TIMEOUT != 0 && wd != WD_W'(TIMEOUT)) begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            COMPUTE: begin
                if (i_fft_done) begin
                    state_nxt      = SEND;
                    run_nxt        = 1'b0;
                    sel_nxt        = '0;
                    start_pend_nxt = 1'b1;
                end
            end
            SEND: begin
                // Start is issued one cycle after o_sel settles so the mux output is stable.
                start_nxt = start_pend;
                if (i_tx_done) begin
                    if (o_sel == SEL_W'(LAST_SEL)) begin
                        state_nxt = IDLE;
                        fdone_nxt = 1'b1;
                        rx_en_nxt = 1'b1;
                    end else begin
                        sel_nxt        = o_sel + SEL_W'(1);
                        start_pend_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_fft_uart_sequencer.sv
// Directed bench for fft_uart_sequencer: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_fft_uart_sequencer;
    logic       i_clk = 1'b0;
    logic       i_rst, i_rx_valid, i_fft_done, i_tx_done;
    logic       o_rx_enable, o_fft_run, o_tx_start, o_busy, o_frame_done, o_error;
    logic [5:0] o_sel;

    typedef struct {int kind; int sel;} exp_t;  // kind: 0 start, 1 frame_done, 2 error
    exp_t q[$];
    int n_checks = 0;
    int n_err    = 0;

    fft_uart_sequencer #(.FFT_SIZE(32), .SEL_W(6), .TIMEOUT(100)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_fft_done(i_fft_done),
        .i_tx_done(i_tx_done), .o_rx_enable(o_rx_enable), .o_fft_run(o_fft_run),
        .o_sel(o_sel), .o_tx_start(o_tx_start), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int sel);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        q.push_back(e);
    endtask

    task automatic mon(input int kind, input int sel);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected event: got kind %0d sel %0d, expected no event", kind, sel);
        end else begin
            e = q.pop_front();
            chk("event kind", kind, e.kind);
            if (kind == 0) chk("tx_start sel", sel, e.sel);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_tx_start)   mon(0, int'(o_sel));
        if (o_frame_done) mon(1, 0);
        if (o_error)      mon(2, 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_rx();
        i_rx_valid = 1'b1; tick(1); i_rx_valid = 1'b0;
    endtask

    task automatic pulse_tx();
        i_tx_done = 1'b1; tick(1); i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; tick(1);
        chk("rst rx_enable", o_rx_enable, 1);
        chk("rst fft_run", o_fft_run, 0);
        chk("rst sel", o_sel, 0);
        chk("rst tx_start", o_tx_start, 0);
        chk("rst busy", o_busy, 0);
        chk("rst frame_done", o_frame_done, 0);
        chk("rst error", o_error, 0);
        i_rst = 1'b0;
    endtask

    // Streams result bytes; stops right after o_sel reaches stop_sel (64 = whole frame).
    task automatic send_bytes(input int stop_sel, input bit stray);
        bit ok;
        for (int s = 0; s < 64; s++) begin
            if (s == stop_sel) begin
                chk("sel at stop", o_sel, stop_sel);
                return;
            end
            push(0, s);
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                if (o_tx_start) ok = 1'b1;
                else tick(1);
            end
            if (!ok) begin
                chk("tx_start seen before timeout", 0, 1);
                return;
            end
            chk("sel during byte", o_sel, s);
            if (stray && s == 5) begin
                tick(9); pulse_rx();
                chk("stray rx sel", o_sel, s);
                chk("stray rx fft_run", o_fft_run, 0);
                tick(9);
            end else begin
                tick(19);
            end
            if (s == 63) push(1, 0);
            pulse_tx();
            if (s == 63) begin
                chk("last frame_done", o_frame_done, 1);
                chk("last busy", o_busy, 0);
                chk("last rx_enable", o_rx_enable, 1);
            end
        end
    endtask

    task automatic run_frame(input int stop_sel, input bit stray, input bit hold_done);
        if (hold_done) i_fft_done = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) begin
                if (stray) begin
                    tick(4); pulse_tx(); tick(4);
                end else tick(9);
            end
            pulse_rx();
            if (i == 0) begin
                chk("byte1 fft_run", o_fft_run, 1);
                chk("byte1 busy", o_busy, 1);
            end
            if (i == 30) chk("byte31 rx_enable", o_rx_enable, 1);
            if (i == 31) begin
                chk("byte32 rx_enable", o_rx_enable, 0);
                chk("byte32 fft_run", o_fft_run, 1);
            end
        end
        if (hold_done) begin
            tick(1);
            i_fft_done = 1'b0;
        end else begin
            if (stray) begin
                tick(20); pulse_rx();
                chk("compute stray rx_enable", o_rx_enable, 0);
                chk("compute stray fft_run", o_fft_run, 1);
                tick(28);
            end else tick(49);
            i_fft_done = 1'b1; tick(1); i_fft_done = 1'b0;
        end
        chk("compute exit fft_run", o_fft_run, 0);
        chk("compute exit sel", o_sel, 0);
        send_bytes(stop_sel, stray);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_rx_valid = 1'b0; i_fft_done = 1'b0; i_tx_done = 1'b0;
        tick(3);
        do_reset();
        tick(2);

        // Abort mid-SEND with reset, then a clean frame.
        run_frame(17, 1'b0, 1'b0);
        do_reset();
        tick(3);
        run_frame(64, 1'b0, 1'b0);
        tick(5);

        // Watchdog: 5 bytes then silence; expires exactly 100 cycles after byte 5.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(9);
            pulse_rx();
        end
        tick(99);
        chk("wd not yet error", o_error, 0);
        chk("wd not yet busy", o_busy, 1);
        push(2, 0);
        tick(1);
        chk("wd error", o_error, 1);
        chk("wd fft_run", o_fft_run, 0);
        chk("wd busy", o_busy, 0);
        chk("wd rx_enable", o_rx_enable, 1);
        tick(3);
        // Fresh count of 1: the frame must close on exactly the 32nd byte.
        run_frame(64, 1'b1, 1'b0);
        tick(4);

        // fft_done held through COLLECT, then back-to-back frame start.
        run_frame(64, 1'b0, 1'b1);
        pulse_rx();
        chk("b2b fft_run", o_fft_run, 1);
        chk("b2b busy", o_busy, 1);
        chk("b2b rx_enable", o_rx_enable, 1);
        do_reset();
        tick(3);

        chk("scoreboard empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
